swervolf_wb_initiator: RTL

//  Wishbone classic single-transfer initiator: the bus-master end for SoC-level responders such as the system controller.

---
 rtl/swervolf_wb_pkg.sv | 18 +
 rtl/swervolf_wb_initiator.sv | 120 ++++++++++++
 2 files changed

// File: rtl/swervolf_wb_pkg.sv
// Shared types and constants for the SweRVolf Wishbone single-transfer initiator.
package swervolf_wb_pkg;

  typedef enum logic [1:0] {
    WBI_IDLE = 2'd0,
    WBI_BUS  = 2'd1,
    WBI_RESP = 2'd2
  } wbi_state_t;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  // A disabled timeout (0) still needs a 1-bit counter to keep the datapath legal.
  function automatic int timeout_cnt_w(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/swervolf_wb_initiator.sv
// Wishbone classic single-transfer initiator: one command in, one non-pipelined
// WB cycle out, one response back, with an ack timeout so a dead responder cannot hang us.
module swervolf_wb_initiator
  import swervolf_wb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [ADDR_W-1:0]    i_cmd_adr,
  input  logic [WB_DATA_W-1:0] i_cmd_dat,
  input  logic [WB_SEL_W-1:0]  i_cmd_sel,
  input  logic                 i_cmd_we,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [WB_DATA_W-1:0] o_rsp_rdt,
  output logic                 o_rsp_err,
  output logic [ADDR_W-1:0]    o_wb_adr,
  output logic [WB_DATA_W-1:0] o_wb_dat,
  output logic [WB_SEL_W-1:0]  o_wb_sel,
  output logic                 o_wb_we,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  input  logic [WB_DATA_W-1:0] i_wb_rdt,
  input  logic                 i_wb_ack
);

  localparam int  CNT_W      = timeout_cnt_w(TIMEOUT_CYCLES);
  localparam bit  TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  wbi_state_t       state;
  wbi_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cmd_fire;
  logic             timeout_hit;

  assign cmd_fire = i_cmd_valid && o_cmd_ready;

  // The counter holds the number of ack-less BUS edges already seen, so the
  // edge that would make it reach TIMEOUT_CYCLES is the one that gives up.
  assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST) && !i_wb_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= WBI_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WBI_IDLE: if (cmd_fire)                 state_nxt = WBI_BUS;
      WBI_BUS:  if (i_wb_ack || timeout_hit)  state_nxt = WBI_RESP;
      WBI_RESP: if (i_rsp_ready)              state_nxt = WBI_IDLE;
      default:                                state_nxt = WBI_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = (state == WBI_IDLE) && !i_rst;
    o_wb_stb    = o_wb_cyc;
  end

  // Registered bus and response outputs; WB address/data/sel/we keep their
  // last values after the cycle ends so a bus monitor sees stable lines.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_adr    <= '0;
      o_wb_dat    <= '0;
      o_wb_sel    <= '0;
      o_wb_we     <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdt   <= '0;
      o_rsp_err   <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        WBI_IDLE: begin
          if (cmd_fire) begin
            o_wb_adr <= i_cmd_adr;
            o_wb_dat <= i_cmd_dat;
            o_wb_sel <= i_cmd_sel;
            o_wb_we  <= i_cmd_we;
            o_wb_cyc <= 1'b1;
            cnt      <= '0;
          end
        end
        WBI_BUS: begin
          if (i_wb_ack) begin
            o_wb_cyc    <= 1'b0;
            o_rsp_rdt   <= o_wb_we ? '0 : i_wb_rdt;
            o_rsp_err   <= 1'b0;
            o_rsp_valid <= 1'b1;
          end else if (timeout_hit) begin
            o_wb_cyc    <= 1'b0;
            o_rsp_rdt   <= '0;
            o_rsp_err   <= 1'b1;
            o_rsp_valid <= 1'b1;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        WBI_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
          end
        end
        default: o_wb_cyc <= 1'b0;
      endcase
    end
  end

endmodule
